// File: rtl/ama_riscv_fetch_q_pkg.sv
// Shared types and constants for the ama_riscv fetch unit and its prefetch queue.
package ama_riscv_fetch_q_pkg;

  typedef enum logic [0:0] {
    FETCH_RUN   = 1'b0,
    FETCH_DRAIN = 1'b1
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h4000_0000;

  // Sequential word-aligned PC step; wraps modulo 2^32.
  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/ama_riscv_fifo.sv
// Synchronous FIFO with synchronous clear and a registered head (array entry at read pointer).
module ama_riscv_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             pop_ok;
  logic             push_ok;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      cnt <= cnt + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/ama_riscv_fetch_q.sv
// In-order fetch unit with credit-limited requests and a prefetch queue.
// Optional bubble counter port enabled by defining AMA_FETCH_PERF_CNT_EN.
module ama_riscv_fetch_q
  import ama_riscv_fetch_q_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
`ifdef AMA_FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_bubble_cnt
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_t  state;
  fetch_state_t  state_nxt;
  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] count;
  logic [CW:0]   credit_used;
  logic          req_fire;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [63:0]   head;

  assign imem_req_addr = fetch_pc;
  assign req_fire      = imem_req_valid && imem_req_ready;
  // Responses are only kept in RUN and never in the redirect cycle itself.
  assign push          = imem_rsp_valid && (state == FETCH_RUN) && !redirect_valid;
  assign pop           = inst_valid && inst_ready;
  assign inst_valid    = !empty;
  assign inst          = head[63:32];
  assign inst_pc       = head[31:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    imem_req_valid = 1'b0;
    credit_used    = {1'b0, outstanding} + {1'b0, count};
    if (!rst && (state == FETCH_RUN) && !redirect_valid &&
        (credit_used < (CW+1)'(DEPTH))) begin
      imem_req_valid = 1'b1;
    end
    if (redirect_valid) begin
      state_nxt = (outstanding > CW'(imem_rsp_valid)) ? FETCH_DRAIN : FETCH_RUN;
    end else if ((state == FETCH_DRAIN) && imem_rsp_valid && (outstanding == CW'(1))) begin
      state_nxt = FETCH_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        rsp_pc   <= redirect_pc;
      end else begin
        if (req_fire) fetch_pc <= pc_next(fetch_pc);
        if (push)     rsp_pc   <= pc_next(rsp_pc);
      end
    end
  end

  ama_riscv_fifo #(
    .WIDTH(64),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (redirect_valid),
    .push     (push),
    .push_data({imem_rsp_data, rsp_pc}),
    .pop      (pop),
    .full     (full),
    .empty    (empty),
    .head     (head),
    .count    (count)
  );

  // Credit rule keeps outstanding + count <= DEPTH, so a push never meets a full queue.
  assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

`ifdef AMA_FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_bubble_cnt <= '0;
    end else if (inst_ready && !inst_valid && (perf_bubble_cnt != '1)) begin
      perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ama_riscv_fetch_q.sv
// Scoreboard bench for ama_riscv_fetch_q: in-order memory model, directed redirect/stall/wrap scenarios.
module tb_ama_riscv_fetch_q;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
`ifdef AMA_FETCH_PERF_CNT_EN
  logic [31:0] perf_bubble_cnt;
`endif

  ama_riscv_fetch_q #(
    .RESET_PC(32'h4000_0000),
    .DEPTH   (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc)
`ifdef AMA_FETCH_PERF_CNT_EN
    ,
    .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  int unsigned pops   = 0;
  int unsigned req_cnt = 0;
  int unsigned lat    = 1;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } mreq_t;
  mreq_t mq[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_reload(input logic [31:0] pc);
    exp_q.delete();
    for (int i = 0; i < 40; i++) exp_q.push_back(pc + 32'(4 * i));
  endtask

  task automatic tick(input logic rdy);
    @(negedge clk);
    redirect_valid = 1'b0;
    inst_ready     = rdy;
    #1;
  endtask

  // Checks after a redirect happen at +3, once the scoreboard has been reloaded.
  task automatic redir(input logic [31:0] pc, input logic rdy);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    inst_ready     = rdy;
    #3;
    exp_reload(pc);
  endtask

  // Memory: fixed latency per request, in-order, never back-pressured.
  initial begin
    int unsigned cyc;
    cyc = 0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        mq.delete();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end else if (mq.size() > 0 && mq[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end
      #2;
      if (!rst && imem_req_valid && imem_req_ready) begin
        mq.push_back('{imem_req_addr, cyc + lat});
        req_cnt++;
      end
    end
  end

  // Monitor: every consumed instruction must be the next one in the expected stream.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && inst_valid && inst_ready) begin
        pops++;
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_inst_pc", inst_pc, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("sb_inst_pc", inst_pc, e);
          chk("sb_inst", inst, mem_word(e));
        end
      end
    end
  end

  initial begin
    int unsigned p0;
    int unsigned r0;
    rst            = 1'b1;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, 0);
`ifdef AMA_FETCH_PERF_CNT_EN
    chk("rst_perf", perf_bubble_cnt, 0);
`endif

    // Reset release, latency 1, inst_ready high.
    exp_reload(32'h4000_0000);
    @(negedge clk);
    rst = 1'b0;
    inst_ready = 1'b1;
    #1;
    chk("p1_c0_req_valid", imem_req_valid, 1);
    chk("p1_c0_req_addr", imem_req_addr, 32'h4000_0000);
    chk("p1_c0_inst_valid", inst_valid, 0);
    tick(1);
    chk("p1_c1_req_addr", imem_req_addr, 32'h4000_0004);
    chk("p1_c1_inst_valid", inst_valid, 0);
    tick(1);
    chk("p1_c2_req_valid", imem_req_valid, 0);
    chk("p1_c2_inst_pc", inst_pc, 32'h4000_0000);
    tick(1);
    chk("p1_c3_req_addr", imem_req_addr, 32'h4000_0008);
    chk("p1_c3_inst_pc", inst_pc, 32'h4000_0004);
    tick(1);
    tick(1);
`ifdef AMA_FETCH_PERF_CNT_EN
    chk("p1_perf_bubbles", perf_bubble_cnt, 3);
`endif
    repeat (8) tick(1);

    // Stall: redirect with decode blocked; exactly DEPTH requests go out.
    redir(32'h4000_0040, 0);
    r0 = req_cnt;
    repeat (8) tick(0);
    chk("p2_req_count", req_cnt - r0, 2);
    chk("p2_req_held", imem_req_valid, 0);
    chk("p2_head_valid", inst_valid, 1);
    chk("p2_head_pc", inst_pc, 32'h4000_0040);
    p0 = pops;
    repeat (10) tick(1);
    chk("p2_resume_pops", 32'(pops - p0 >= 5), 1);

    // Redirect with 2 outstanding at latency 3.
    repeat (10) tick(0);
    lat = 3;
    redir(32'h4000_0080, 0);
    tick(1);
    chk("p3_req_a", imem_req_addr, 32'h4000_0080);
    tick(1);
    chk("p3_req_b", imem_req_addr, 32'h4000_0084);
    redir(32'h4000_0100, 1);
    chk("p3_redir_gate", imem_req_valid, 0);
    tick(1);
    chk("p3_drain1_req", imem_req_valid, 0);
    chk("p3_drain1_inst_valid", inst_valid, 0);
    tick(1);
    chk("p3_drain2_req", imem_req_valid, 0);
    tick(1);
    chk("p3_new_req_valid", imem_req_valid, 1);
    chk("p3_new_req_addr", imem_req_addr, 32'h4000_0100);
    repeat (4) tick(1);
    chk("p3_first_inst_valid", inst_valid, 1);
    chk("p3_first_inst_pc", inst_pc, 32'h4000_0100);
    repeat (6) tick(1);

    // Redirect coinciding with a response and an output handshake.
    repeat (12) tick(0);
    lat = 1;
    redir(32'h4000_0300, 0);
    tick(1);
    tick(1);
    redir(32'h4000_0400, 1);
    chk("p4_head_valid", inst_valid, 1);
    chk("p4_head_pc", inst_pc, 32'h4000_0300);
    tick(1);
    chk("p4_no_stale_valid", inst_valid, 0);
    chk("p4_req_addr", imem_req_addr, 32'h4000_0400);
    chk("p4_req_valid", imem_req_valid, 1);
    repeat (6) tick(1);

    // Back-to-back redirects while draining.
    repeat (12) tick(0);
    lat = 3;
    redir(32'h4000_0500, 0);
    tick(1);
    chk("p5_req_a", imem_req_addr, 32'h4000_0500);
    tick(1);
    redir(32'h0000_0100, 1);
    redir(32'h0000_0200, 1);
    chk("p5_redir2_gate", imem_req_valid, 0);
    tick(1);
    chk("p5_drain_req", imem_req_valid, 0);
    tick(1);
    chk("p5_new_req_valid", imem_req_valid, 1);
    chk("p5_new_req_addr", imem_req_addr, 32'h0000_0200);
    p0 = pops;
    repeat (8) tick(1);
    chk("p5_pops", 32'(pops - p0 >= 2), 1);

    // Address wrap, with one cycle of memory back-pressure on the first request.
    repeat (12) tick(0);
    lat = 1;
    redir(32'hFFFF_FFF8, 0);
    imem_req_ready = 1'b0;
    tick(1);
    chk("p6_c0_req_addr", imem_req_addr, 32'hFFFF_FFF8);
    tick(1);
    chk("p6_c1_req_hold", imem_req_addr, 32'hFFFF_FFF8);
    chk("p6_c1_req_valid", imem_req_valid, 1);
    imem_req_ready = 1'b1;
    tick(1);
    chk("p6_c2_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    tick(1);
    chk("p6_c3_req_valid", imem_req_valid, 0);
    tick(1);
    chk("p6_c4_req_valid", imem_req_valid, 1);
    chk("p6_wrap_addr", imem_req_addr, 32'h0000_0000);
    p0 = pops;
    repeat (6) tick(1);
    chk("p6_pops", 32'(pops - p0 >= 3), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
